// File: rtl/segment_update_engine.sv
`default_nettype none
// ============================================================================
// segment_update_engine : walks every key fragment of an insert/delete request,
//   doing a read-modify-write of that fragment's SDRAM segment.
//   Optional macro SEG_ENGINE_STATS_EN adds saturating write/collision counters.
// Revision: 1.0
// ============================================================================
module segment_update_engine #(
   parameter int DATA_BITS = 10,
   parameter int FRAGMENTS = 5,
   parameter int FRAG_BITS = 3,
   parameter int IDWID     = 2,
   parameter int MASKWID   = 5,
   localparam int FRAG_WID = DATA_BITS / FRAGMENTS,
   localparam int ADDR_WID = FRAG_BITS + FRAG_WID,
   localparam int PRIOWID  = IDWID,
   localparam int SEGWID   = 2 + IDWID + MASKWID + DATA_BITS + PRIOWID
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_start,
   input  logic                 i_op,
   input  logic [IDWID-1:0]     i_id,
   input  logic [DATA_BITS-1:0] i_key,
   input  logic [MASKWID-1:0]   i_maskid,
   input  logic [PRIOWID-1:0]   i_priority,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_collision,
   output logic [ADDR_WID-1:0]  o_sdram_address,
   output logic                 o_sdram_read,
   output logic                 o_sdram_write,
   output logic [SEGWID-1:0]    o_sdram_writedata,
   input  logic                 i_sdram_waitrequest,
   input  logic                 i_sdram_readdatavalid,
   input  logic [SEGWID-1:0]    i_sdram_readdata
`ifdef SEG_ENGINE_STATS_EN
   ,
   output logic [15:0]          o_stat_writes,
   output logic [15:0]          o_stat_collisions
`endif
);

   localparam int FIELDS = SEGWID - 2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_COMPUTE = 3'd3,
      S_WR_REQ  = 3'd4,
      S_NEXT    = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t               state_q;
   logic [FRAG_BITS-1:0] frag_q;
   logic                 op_q;
   logic [IDWID-1:0]     id_q;
   logic [DATA_BITS-1:0] key_q;
   logic [MASKWID-1:0]   mask_q;
   logic [PRIOWID-1:0]   prio_q;
   logic [SEGWID-1:0]    rdata_q;

   logic [1:0]           rd_status;
   logic [IDWID-1:0]     rd_id;
   logic [PRIOWID-1:0]   rd_prio;
   logic [FIELDS-1:0]    new_fields;
   logic [SEGWID-1:0]    wr_seg_d;
   logic                 wr_need_d;
   logic                 coll_d;
   logic [FRAG_BITS-1:0] frag_inc;
   logic [FRAG_WID-1:0]  next_bits;
   logic                 last_frag;

   assign rd_status  = rdata_q[SEGWID-1 -: 2];
   assign rd_id      = rdata_q[FIELDS-1 -: IDWID];
   assign rd_prio    = rdata_q[PRIOWID-1:0];
   assign new_fields = {id_q, mask_q, key_q, prio_q};
   assign frag_inc   = frag_q + 1'b1;
   assign next_bits  = key_q[frag_inc*FRAG_WID +: FRAG_WID];
   assign last_frag  = (frag_q == FRAG_BITS'(FRAGMENTS - 1));

   // Segment update decision: status 00 empty, 01 valid, 11 collision.
   always_comb begin
      wr_seg_d  = '0;
      wr_need_d = 1'b0;
      coll_d    = 1'b0;
      if (op_q) begin
         if (rd_status != 2'b00 && rd_id == id_q) begin
            wr_need_d = 1'b1;
         end
      end else if (rd_status == 2'b00) begin
         wr_seg_d  = {2'b01, new_fields};
         wr_need_d = 1'b1;
      end else if (rd_id == id_q) begin
         wr_seg_d  = {rd_status, new_fields};
         wr_need_d = 1'b1;
         coll_d    = (rd_status == 2'b11);
      end else begin
         coll_d = 1'b1;
         if (prio_q < rd_prio) begin
            wr_seg_d  = {2'b11, new_fields};
            wr_need_d = 1'b1;
         end else begin
            wr_seg_d  = {2'b11, rdata_q[FIELDS-1:0]};
            wr_need_d = (rd_status != 2'b11);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q           <= S_IDLE;
         frag_q            <= '0;
         op_q              <= 1'b0;
         id_q              <= '0;
         key_q             <= '0;
         mask_q            <= '0;
         prio_q            <= '0;
         rdata_q           <= '0;
         o_busy            <= 1'b0;
         o_done            <= 1'b0;
         o_collision       <= 1'b0;
         o_sdram_address   <= '0;
         o_sdram_read      <= 1'b0;
         o_sdram_write     <= 1'b0;
         o_sdram_writedata <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               o_done  <= 1'b0;
               state_q <= S_IDLE;
               if (i_start) begin
                  op_q            <= i_op;
                  id_q            <= i_id;
                  key_q           <= i_key;
                  mask_q          <= i_maskid;
                  prio_q          <= i_priority;
                  frag_q          <= '0;
                  o_collision     <= 1'b0;
                  o_busy          <= 1'b1;
                  o_sdram_address <= {{FRAG_BITS{1'b0}}, i_key[FRAG_WID-1:0]};
                  o_sdram_read    <= 1'b1;
                  state_q         <= S_RD_REQ;
               end
            end
            S_RD_REQ: begin
               if (!i_sdram_waitrequest) begin
                  o_sdram_read <= 1'b0;
                  state_q      <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (i_sdram_readdatavalid) begin
                  rdata_q <= i_sdram_readdata;
                  state_q <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               if (coll_d) begin
                  o_collision <= 1'b1;
               end
               if (wr_need_d) begin
                  o_sdram_write     <= 1'b1;
                  o_sdram_writedata <= wr_seg_d;
                  state_q           <= S_WR_REQ;
               end else begin
                  state_q <= S_NEXT;
               end
            end
            S_WR_REQ: begin
               if (!i_sdram_waitrequest) begin
                  o_sdram_write <= 1'b0;
                  state_q       <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (last_frag) begin
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  frag_q          <= frag_inc;
                  o_sdram_address <= {frag_inc, next_bits};
                  o_sdram_read    <= 1'b1;
                  state_q         <= S_RD_REQ;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SEG_ENGINE_STATS_EN
   logic [15:0] stat_writes_q;
   logic [15:0] stat_colls_q;

   // Both counters advance at the compute step, once per fragment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_writes_q <= '0;
         stat_colls_q  <= '0;
      end else if (state_q == S_COMPUTE) begin
         if (wr_need_d && stat_writes_q != 16'hFFFF) begin
            stat_writes_q <= stat_writes_q + 16'd1;
         end
         if (coll_d && stat_colls_q != 16'hFFFF) begin
            stat_colls_q <= stat_colls_q + 16'd1;
         end
      end
   end

   assign o_stat_writes     = stat_writes_q;
   assign o_stat_collisions = stat_colls_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_segment_update_engine.sv
`default_nettype none
// Bench for segment_update_engine: SDRAM slave with random timing, checked
// against a behavioural segment-table model and hand-computed expectations.
module tb_segment_update_engine;
   localparam int DB = 10;
   localparam int FR = 5;
   localparam int FB = 3;
   localparam int IW = 2;
   localparam int MW = 5;
   localparam int FW = 2;
   localparam int AW = 5;
   localparam int SW = 21;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_start = 1'b0;
   logic          i_op = 1'b0;
   logic [IW-1:0] i_id = '0;
   logic [DB-1:0] i_key = '0;
   logic [MW-1:0] i_maskid = '0;
   logic [IW-1:0] i_priority = '0;
   logic          o_busy, o_done, o_collision;
   logic [AW-1:0] o_sdram_address;
   logic          o_sdram_read, o_sdram_write;
   logic [SW-1:0] o_sdram_writedata;
   logic          i_sdram_waitrequest = 1'b0;
   logic          i_sdram_readdatavalid = 1'b0;
   logic [SW-1:0] i_sdram_readdata = '0;

   segment_update_engine dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .i_start               (i_start),
      .i_op                  (i_op),
      .i_id                  (i_id),
      .i_key                 (i_key),
      .i_maskid              (i_maskid),
      .i_priority            (i_priority),
      .o_busy                (o_busy),
      .o_done                (o_done),
      .o_collision           (o_collision),
      .o_sdram_address       (o_sdram_address),
      .o_sdram_read          (o_sdram_read),
      .o_sdram_write         (o_sdram_write),
      .o_sdram_writedata     (o_sdram_writedata),
      .i_sdram_waitrequest   (i_sdram_waitrequest),
      .i_sdram_readdatavalid (i_sdram_readdatavalid),
      .i_sdram_readdata      (i_sdram_readdata)
   );

   always #5 clk = ~clk;

   int               checks = 0;
   int               errors = 0;
   bit               slow = 1'b0;
   logic [SW-1:0]    mem [32];
   logic [SW-1:0]    ref_mem [32];
   logic [AW-1:0]    exp_rd [$];
   logic [AW+SW-1:0] exp_wr [$];
   logic [AW-1:0]    wr_log [$];
   logic [SW-1:0]    wrd_log [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] faddr(input logic [DB-1:0] k, input int f);
      logic [AW-1:0] a;
      a[AW-1:FW] = FB'(f);
      a[FW-1:0]  = k[f*FW +: FW];
      return a;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
   endtask

   // Reference: table of segments updated by the insert/delete rules.
   task automatic model_req(input logic op, input logic [IW-1:0] id, input logic [DB-1:0] key,
                            input logic [MW-1:0] mask, input logic [IW-1:0] prio, output logic coll);
      logic [SW-1:0]   s, n;
      logic [AW-1:0]   a;
      logic [SW-3:0]   newf;
      bit              w;
      coll = 1'b0;
      newf = {id, mask, key, prio};
      for (int f = 0; f < FR; f++) begin
         a = faddr(key, f);
         exp_rd.push_back(a);
         s = ref_mem[a];
         w = 1'b0;
         n = '0;
         if (op) begin
            w = (s[20:19] != 2'b00) && (s[18:17] == id);
         end else if (s[20:19] == 2'b00) begin
            w = 1'b1; n = {2'b01, newf};
         end else if (s[18:17] == id) begin
            w = 1'b1; n = {s[20:19], newf};
            if (s[20:19] == 2'b11) coll = 1'b1;
         end else begin
            coll = 1'b1;
            if (prio < s[1:0]) begin
               w = 1'b1; n = {2'b11, newf};
            end else if (s[20:19] != 2'b11) begin
               w = 1'b1; n = {2'b11, s[18:0]};
            end
         end
         if (w) begin
            ref_mem[a] = n;
            exp_wr.push_back({a, n});
         end
      end
   endtask

   task automatic do_req(input logic op, input logic [IW-1:0] id, input logic [DB-1:0] key,
                         input logic [MW-1:0] mask, input logic [IW-1:0] prio, input string tag);
      logic ec;
      int   n;
      bit   seen;
      model_req(op, id, key, mask, prio, ec);
      wr_log.delete();
      wrd_log.delete();
      n = 0;
      while (o_busy && n < 100) begin @(negedge clk); n++; end
      i_start = 1'b1; i_op = op; i_id = id; i_key = key; i_maskid = mask; i_priority = prio;
      @(negedge clk);
      i_start = 1'b0;
      i_op = 1'($urandom); i_id = IW'($urandom); i_key = DB'($urandom);
      i_maskid = MW'($urandom); i_priority = IW'($urandom);
      chk({tag, "_busy"}, 32'(o_busy), 1);
      chk({tag, "_coll_cleared"}, 32'(o_collision), 0);
      seen = 1'b0;
      n = 0;
      while (n < 3000) begin
         if (o_done) begin seen = 1'b1; break; end
         i_start = ($urandom_range(0, 5) == 0);
         if (i_start) begin
            i_op = 1'($urandom); i_id = IW'($urandom); i_key = DB'($urandom);
         end
         @(negedge clk);
         n++;
      end
      i_start = 1'b0;
      chk({tag, "_done_seen"}, 32'(seen), 1);
      if (seen) begin
         chk({tag, "_collision"}, 32'(o_collision), 32'(ec));
         chk({tag, "_busy_at_done"}, 32'(o_busy), 0);
         chk({tag, "_writes_left"}, 32'(exp_wr.size()), 0);
         chk({tag, "_reads_left"}, 32'(exp_rd.size()), 0);
      end
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(o_done), 0);
   endtask

   // SDRAM slave and per-cycle bus checks.
   initial begin
      bit            held, rd_pend, acc_rd, acc_wr, h_rd;
      int            wcnt, rdel;
      logic [AW-1:0] h_addr, acc_addr;
      logic [SW-1:0] h_data, acc_data, rd_data;
      logic [AW+SW-1:0] e;
      held = 0; rd_pend = 0; acc_rd = 0; acc_wr = 0; h_rd = 0;
      wcnt = 0; rdel = 0; h_addr = '0; acc_addr = '0; h_data = '0; acc_data = '0; rd_data = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            held = 0; rd_pend = 0; acc_rd = 0; acc_wr = 0;
            i_sdram_waitrequest = 1'b0;
            i_sdram_readdatavalid = 1'b0;
            continue;
         end
         if (acc_rd) begin
            chk("unexpected_read", 32'(exp_rd.size() == 0), 0);
            if (exp_rd.size() != 0) chk("read_addr", 32'(acc_addr), 32'(exp_rd.pop_front()));
            rd_data = mem[acc_addr];
            rd_pend = 1;
            rdel = slow ? $urandom_range(1, 6) : 1;
         end
         if (acc_wr) begin
            mem[acc_addr] = acc_data;
            wr_log.push_back(acc_addr);
            wrd_log.push_back(acc_data);
            chk("unexpected_write", 32'(exp_wr.size() == 0), 0);
            if (exp_wr.size() != 0) begin
               e = exp_wr.pop_front();
               chk("write_addr", 32'(acc_addr), 32'(e[AW+SW-1:SW]));
               chk("write_data", 32'(acc_data), 32'(e[SW-1:0]));
            end
         end
         acc_rd = 0;
         acc_wr = 0;
         i_sdram_readdatavalid = 1'b0;
         i_sdram_readdata = SW'($urandom);
         if (rd_pend) begin
            rdel--;
            if (rdel == 0) begin
               i_sdram_readdatavalid = 1'b1;
               i_sdram_readdata = rd_data;
               rd_pend = 0;
            end
         end else if (slow && $urandom_range(0, 3) == 0) begin
            i_sdram_readdatavalid = 1'b1;
         end
         chk("rd_wr_exclusive", 32'(o_sdram_read & o_sdram_write), 0);
         if (o_sdram_read || o_sdram_write) begin
            if (!held) begin
               held = 1;
               wcnt = slow ? $urandom_range(0, 4) : 0;
               h_addr = o_sdram_address; h_data = o_sdram_writedata; h_rd = o_sdram_read;
            end else begin
               chk("addr_stable", 32'(o_sdram_address), 32'(h_addr));
               chk("kind_stable", 32'(o_sdram_read), 32'(h_rd));
               if (!h_rd) chk("data_stable", 32'(o_sdram_writedata), 32'(h_data));
            end
            if (wcnt == 0) begin
               i_sdram_waitrequest = 1'b0;
               acc_rd = o_sdram_read; acc_wr = o_sdram_write;
               acc_addr = o_sdram_address; acc_data = o_sdram_writedata;
               held = 0;
            end else begin
               i_sdram_waitrequest = 1'b1;
               wcnt--;
            end
         end else begin
            chk("req_dropped", 32'(held), 0);
            held = 0;
            i_sdram_waitrequest = slow ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] t1a [5];
      logic [DB-1:0] k2, keys [4];
      logic [AW-1:0] a;
      logic          ec;
      int            n;
      t1a[0] = 5'd3; t1a[1] = 5'd4; t1a[2] = 5'd9; t1a[3] = 5'd14; t1a[4] = 5'd19;
      clear_mem();
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_coll", 32'(o_collision), 0);
      chk("rst_read", 32'(o_sdram_read), 0);
      chk("rst_write", 32'(o_sdram_write), 0);
      chk("rst_addr", 32'(o_sdram_address), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single insert into empty memory
      do_req(1'b0, 2'd1, 10'b1110010011, 5'h0A, 2'd2, "t1");
      chk("t1_nwrites", 32'(wr_log.size()), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < wr_log.size()) begin
            chk("t1_addr", 32'(wr_log[i]), 32'(t1a[i]));
            chk("t1_status", 32'(wrd_log[i][20:19]), 1);
         end
      end
      if (wrd_log.size() > 0)
         chk("t1_data0", 32'(wrd_log[0]), 32'({2'b01, 2'd1, 5'h0A, 10'b1110010011, 2'd2}));
      chk("t1_coll", 32'(o_collision), 0);

      // Newer rule with better priority takes over
      clear_mem();
      k2 = 10'b0110110001;
      do_req(1'b0, 2'd1, k2, 5'h03, 2'd2, "t2a");
      do_req(1'b0, 2'd2, k2, 5'h11, 2'd1, "t2b");
      chk("t2_coll", 32'(o_collision), 1);
      for (int f = 0; f < FR; f++) begin
         a = faddr(k2, f);
         chk("t2_status", 32'(mem[a][20:19]), 3);
         chk("t2_id", 32'(mem[a][18:17]), 2);
      end

      // Worse priority keeps stored fields, status 11
      clear_mem();
      do_req(1'b0, 2'd1, k2, 5'h03, 2'd2, "t3a");
      do_req(1'b0, 2'd2, k2, 5'h11, 2'd3, "t3b");
      chk("t3_coll", 32'(o_collision), 1);
      for (int f = 0; f < FR; f++) begin
         a = faddr(k2, f);
         chk("t3_seg", 32'(mem[a]), 32'({2'b11, 2'd1, 5'h03, k2, 2'd2}));
      end

      // Delete: mismatched ID writes nothing, matching ID zeroes
      clear_mem();
      do_req(1'b0, 2'd1, k2, 5'h07, 2'd0, "t4a");
      do_req(1'b1, 2'd3, k2, 5'h00, 2'd0, "t4b");
      chk("t4b_nwrites", 32'(wr_log.size()), 0);
      do_req(1'b1, 2'd1, k2, 5'h00, 2'd0, "t4c");
      chk("t4c_nwrites", 32'(wr_log.size()), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < wrd_log.size()) chk("t4c_zero", 32'(wrd_log[i]), 0);
      end

      // Random ops with wait states and late/spurious read data
      slow = 1'b1;
      clear_mem();
      for (int i = 0; i < 4; i++) keys[i] = DB'($urandom);
      for (int r = 0; r < 36; r++) begin
         do_req(($urandom_range(0, 9) < 3), IW'($urandom), keys[$urandom_range(0, 3)],
                MW'($urandom), IW'($urandom), "rnd");
      end
      for (int i = 0; i < 32; i++) chk("rnd_mem", 32'(mem[i]), 32'(ref_mem[i]));

      // Reset during the write of fragment 2
      slow = 1'b0;
      repeat (3) @(negedge clk);
      clear_mem();
      exp_rd.delete(); exp_wr.delete();
      model_req(1'b0, 2'd1, k2, 5'h05, 2'd1, ec);
      i_start = 1'b1; i_op = 1'b0; i_id = 2'd1; i_key = k2; i_maskid = 5'h05; i_priority = 2'd1;
      @(negedge clk);
      i_start = 1'b0;
      n = 0;
      while (!(o_sdram_write && o_sdram_address[AW-1:FW] == 3'd2) && n < 500) begin
         @(negedge clk); n++;
      end
      chk("t6_reached_wr2", 32'(n < 500), 1);
      #1 reset_n = 1'b0;
      #1;
      chk("t6_rst_write", 32'(o_sdram_write), 0);
      chk("t6_rst_read", 32'(o_sdram_read), 0);
      chk("t6_rst_busy", 32'(o_busy), 0);
      chk("t6_rst_addr", 32'(o_sdram_address), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_no_done", 32'(o_done), 0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      exp_rd.delete(); exp_wr.delete();
      clear_mem();
      do_req(1'b0, 2'd2, k2, 5'h09, 2'd3, "t6b");
      chk("t6b_nwrites", 32'(wr_log.size()), 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
